bus_master_seq: RTL and testbench



---
 rtl/bus_master_seq.sv | 149 ++++++++++++++
 tb/tb_bus_master_seq.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_seq.sv
// bus_master_seq: upstream master for a shared tri-state address/data bus.
// Turns valid/ready commands into sequenced write and read bus cycles with
// explicit turnaround gaps, and returns read data on a response interface.
// The FSM runs on the rising edge; everything that touches the bus is
// relaunched on the falling edge so the slave sees half a cycle of setup
// and hold around its own rising-edge sample.

module bus_master_seq #(
    parameter int WIDTH   = 32,
    parameter int RD_WAIT = 1,
    parameter int TURN    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    inout  wire  [WIDTH-1:0] ad,
    output logic             read,
    output logic             write
);

    localparam int MAX_WAIT = (RD_WAIT > TURN) ? RD_WAIT : TURN;
    localparam int CW       = $clog2(MAX_WAIT) + 1;

    // Counters are loaded with length-1 on state entry and the state is left
    // once the counter reads zero, so each timed state lasts exactly its length.
    localparam logic [CW-1:0] TURN_LOAD = CW'(TURN - 1);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(RD_WAIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DRIVE,
        ST_WR_HOLD,
        ST_TURN_OUT,
        ST_RD_TURN,
        ST_RD_WAIT,
        ST_RD_RELEASE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] wr_data;
    logic             ad_en;
    logic [WIDTH-1:0] ad_out;

    // Command acceptance, bus-cycle sequencing and read-response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cmd_ready <= 1'b0;
            wr_data   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        wr_data   <= cmd_data;
                        if (cmd_write) begin
                            state <= ST_WR_DRIVE;
                        end else begin
                            state <= ST_RD_TURN;
                            cnt   <= TURN_LOAD;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_WR_DRIVE: begin
                    state <= ST_WR_HOLD;
                end
                ST_WR_HOLD: begin
                    state <= ST_TURN_OUT;
                    cnt   <= TURN_LOAD;
                end
                ST_TURN_OUT: begin
                    if (cnt == '0) begin
                        state     <= ST_IDLE;
                        cmd_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_RD_TURN: begin
                    if (cnt == '0) begin
                        state <= ST_RD_WAIT;
                        cnt   <= WAIT_LOAD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_RD_WAIT: begin
                    if (cnt == '0) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= ad;
                        rsp_err   <= ((^ad) === 1'bx);
                        state     <= ST_RD_RELEASE;
                        cnt       <= TURN_LOAD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_RD_RELEASE: begin
                    if (cnt == '0) begin
                        state     <= ST_IDLE;
                        cmd_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b0;
                end
            endcase
        end
    end

    // Bus-facing strobes launched half a cycle after the state change; the
    // drive enable and the slave read enable come from disjoint states.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ad_en  <= 1'b0;
            ad_out <= '0;
            write  <= 1'b0;
            read   <= 1'b1;
        end else begin
            ad_en  <= (state == ST_WR_DRIVE) || (state == ST_WR_HOLD);
            ad_out <= wr_data;
            write  <= (state == ST_WR_DRIVE);
            read   <= (state != ST_RD_WAIT);
        end
    end

    // One tri-state buffer per bus bit, all sharing the master drive enable.
    for (genvar i = 0; i < WIDTH; i++) begin : g_ad_buf
        bufif1 u_buf (ad[i], ad_out[i], ad_en);
    end

endmodule

// File: tb/tb_bus_master_seq.sv
// tb_bus_master_seq: scoreboard bench for bus_master_seq with a simple
// register slave on the bus. A second instance uses RD_WAIT=3 for the
// back-to-back scenario.

module tb_bus_master_seq;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        cmd_valid, cmd_write, cmd_ready;
    logic [31:0] cmd_data;
    logic        rsp_valid, rsp_err, read, write;
    logic [31:0] rsp_data;
    wire  [31:0] ad;

    logic        cmd_valid3, cmd_write3, cmd_ready3;
    logic [31:0] cmd_data3;
    logic        rsp_valid3, rsp_err3, read3, write3;
    logic [31:0] rsp_data3;
    wire  [31:0] ad3;

    int   errors = 0;
    int   checks = 0;
    logic four_state;

    typedef struct packed {
        logic        flt;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    bus_master_seq #(.WIDTH(32), .RD_WAIT(1), .TURN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ad(ad), .read(read), .write(write)
    );

    bus_master_seq #(.WIDTH(32), .RD_WAIT(3), .TURN(1)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_write(cmd_write3), .cmd_data(cmd_data3),
        .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .rsp_err(rsp_err3),
        .ad(ad3), .read(read3), .write(write3)
    );

    // Register slave on the main bus; can be detached to leave the bus floating.
    logic        slave_on;
    logic [15:0] slave_reg = 16'h0000;
    always @(posedge clk) if (slave_on && write) slave_reg <= ad[15:0];
    assign ad = (slave_on && !read) ? {16'h0000, slave_reg} : 32'hzzzz_zzzz;

    // Always-attached register slave for the RD_WAIT=3 instance.
    logic [15:0] slave_reg3 = 16'h0000;
    always @(posedge clk) if (write3) slave_reg3 <= ad3[15:0];
    assign ad3 = (!read3) ? {16'h0000, slave_reg3} : 32'hzzzz_zzzz;

    function automatic exp_t mk_exp(logic flt, logic err, logic [31:0] data);
        exp_t e;
        e.flt  = flt;
        e.err  = err;
        e.data = data;
        return e;
    endfunction

    function automatic logic all_unknown(logic [31:0] v);
        for (int i = 0; i < 32; i++) if (!$isunknown(v[i])) return 1'b0;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds a command on the main instance until accepted; returns just after the accepting edge.
    task automatic send_cmd(input logic w, input logic [31:0] d, output logic ok);
        ok        = 1'b0;
        cmd_write = w;
        cmd_data  = d;
        cmd_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (cmd_ready === 1'b1) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic got, output int lat, output logic [31:0] d, output logic e);
        got = 1'b0;
        lat = 0;
        d   = '0;
        e   = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                lat = n;
                d   = rsp_data;
                e   = rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        cmd_valid  = 1'b0; cmd_write  = 1'b0; cmd_data  = '0;
        cmd_valid3 = 1'b0; cmd_write3 = 1'b0; cmd_data3 = '0;
        slave_on   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_rsp_data: got %h want 0", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_err: got %b want 0", rsp_err); end
        checks++; if (write !== 1'b0) begin errors++; $display("[TB] FAIL reset_write: got %b want 0", write); end
        checks++; if (read !== 1'b1) begin errors++; $display("[TB] FAIL reset_read: got %b want 1", read); end
        checks++; if (cmd_ready3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_ready3: got %b want 0", cmd_ready3); end
        if (four_state) begin
            checks++; if (all_unknown(ad) !== 1'b1) begin errors++; $display("[TB] FAIL reset_ad_float: got %h want all z", ad); end
        end
        rst_n = 1'b1;
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: got %b want 1", cmd_ready); end
        tick();
    endtask

    task automatic test_write_read();
        logic ok, got, e;
        int lat;
        logic [31:0] d;
        exp_t x;
        slave_on = 1'b1;
        send_cmd(1'b1, 32'haaaa_aaaa, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL wr_accept: got %b want 1", ok); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL wr_busy_ready: got %b want 0", cmd_ready); end
        tick();
        checks++; if (write !== 1'b1) begin errors++; $display("[TB] FAIL wr_strobe_on: got %b want 1", write); end
        tick();
        checks++; if (write !== 1'b0) begin errors++; $display("[TB] FAIL wr_strobe_off: got %b want 0", write); end
        checks++; if (ad !== 32'haaaa_aaaa) begin errors++; $display("[TB] FAIL wr_hold_data: got %h want aaaaaaaa", ad); end
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL wr_idle_3cyc: got %b want 1", cmd_ready); end
        send_cmd(1'b0, 32'h0, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL rd_accept: got %b want 1", ok); end
        sb.push_back(mk_exp(1'b0, 1'b0, 32'h0000_aaaa));
        wait_rsp(got, lat, d, e);
        checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL rd_rsp_seen: got %b want 1", got); end
        checks++; if (lat != 2) begin errors++; $display("[TB] FAIL rd_latency: got %0d want 2", lat); end
        x = sb.pop_front();
        checks++; if (d !== x.data) begin errors++; $display("[TB] FAIL rd_data: got %h want %h", d, x.data); end
        checks++; if (e !== x.err) begin errors++; $display("[TB] FAIL rd_err: got %b want %b", e, x.err); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rd_pulse_width: got %b want 0", rsp_valid); end
    endtask

    task automatic test_reset_mid_write();
        logic ok, got, e;
        int lat, bad;
        logic [31:0] d;
        exp_t x;
        send_cmd(1'b1, 32'h0000_5555, ok);
        #5;
        checks++; if (write !== 1'b1) begin errors++; $display("[TB] FAIL mid_wr_drive: got %b want 1", write); end
        rst_n = 1'b0;
        #1;
        checks++; if (write !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_write: got %b want 0", write); end
        checks++; if (read !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_read: got %b want 1", read); end
        checks++; if (dut.ad_en !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ad_en: got %b want 0", dut.ad_en); end
        if (four_state) begin
            checks++; if (all_unknown(ad) !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_ad_float: got %h want all z", ad); end
        end
        tick();
        rst_n = 1'b1;
        bad = 0;
        repeat (8) begin
            tick();
            if (rsp_valid === 1'b1 || read === 1'b0 || write === 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL mid_rst_quiet: got %0d bus events want 0", bad); end
        send_cmd(1'b0, 32'h0, ok);
        sb.push_back(mk_exp(1'b0, 1'b0, 32'h0000_aaaa));
        wait_rsp(got, lat, d, e);
        x = sb.pop_front();
        checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_rd_seen: got %b want 1", got); end
        checks++; if (d !== x.data) begin errors++; $display("[TB] FAIL mid_rst_rd_data: got %h want %h", d, x.data); end
    endtask

    task automatic test_turnaround();
        logic ok, got, e;
        int lat;
        logic [31:0] d;
        exp_t x;
        send_cmd(1'b1, 32'h0000_3c3c, ok);
        tick();
        tick();
        @(negedge clk);
        #1;
        checks++; if (dut.ad_en !== 1'b0) begin errors++; $display("[TB] FAIL turn_out_en: got %b want 0", dut.ad_en); end
        checks++; if (read !== 1'b1) begin errors++; $display("[TB] FAIL turn_out_read: got %b want 1", read); end
        if (four_state) begin
            checks++; if (all_unknown(ad) !== 1'b1) begin errors++; $display("[TB] FAIL turn_out_ad: got %h want all z", ad); end
        end
        send_cmd(1'b0, 32'h0, ok);
        sb.push_back(mk_exp(1'b0, 1'b0, 32'h0000_3c3c));
        @(negedge clk);
        #1;
        checks++; if (dut.ad_en !== 1'b0) begin errors++; $display("[TB] FAIL rd_turn_en: got %b want 0", dut.ad_en); end
        checks++; if (read !== 1'b1) begin errors++; $display("[TB] FAIL rd_turn_read: got %b want 1", read); end
        if (four_state) begin
            checks++; if (all_unknown(ad) !== 1'b1) begin errors++; $display("[TB] FAIL rd_turn_ad: got %h want all z", ad); end
        end
        wait_rsp(got, lat, d, e);
        x = sb.pop_front();
        checks++; if (d !== x.data) begin errors++; $display("[TB] FAIL turn_rd_data: got %h want %h", d, x.data); end
    endtask

    task automatic test_floating();
        logic ok, got, e;
        int lat;
        logic [31:0] d;
        exp_t x;
        slave_on = 1'b0;
        send_cmd(1'b0, 32'h0, ok);
        sb.push_back(mk_exp(1'b1, 1'b1, 32'h0));
        wait_rsp(got, lat, d, e);
        x = sb.pop_front();
        checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL float_rsp_seen: got %b want 1", got); end
        if (four_state && x.flt) begin
            checks++; if (all_unknown(d) !== 1'b1) begin errors++; $display("[TB] FAIL float_data: got %h want all z", d); end
            checks++; if (e !== x.err) begin errors++; $display("[TB] FAIL float_err: got %b want %b", e, x.err); end
        end
        slave_on = 1'b1;
        tick();
    endtask

    task automatic test_busy_ignore();
        logic ok;
        int bad;
        send_cmd(1'b1, 32'h0000_0f0f, ok);
        tick();
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL busy_ready: got %b want 0", cmd_ready); end
        cmd_write = 1'b0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        bad = 0;
        repeat (10) begin
            if (read === 1'b0 || rsp_valid === 1'b1) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL busy_ignored: got %0d read events want 0", bad); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL busy_back_idle: got %b want 1", cmd_ready); end
    endtask

    task automatic test_random_invariant();
        logic ok, acc;
        logic [15:0] model;
        int viol, unexp;
        exp_t x;
        send_cmd(1'b1, 32'hdead_1357, ok);
        model = 16'h1357;
        viol  = 0;
        unexp = 0;
        acc   = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (rsp_valid === 1'b1) begin
                if (sb.size() == 0) unexp++;
                else begin
                    x = sb.pop_front();
                    checks++; if (rsp_data !== x.data) begin errors++; $display("[TB] FAIL rand_rd_data: got %h want %h", rsp_data, x.data); end
                end
            end
            if (acc || cmd_valid !== 1'b1) begin
                cmd_valid = ($urandom_range(0, 2) != 0);
                cmd_write = 1'($urandom_range(0, 1));
                cmd_data  = $urandom;
            end
            acc = cmd_valid && cmd_ready;
            if (acc) begin
                if (cmd_write) model = cmd_data[15:0];
                else sb.push_back(mk_exp(1'b0, 1'b0, {16'h0000, model}));
            end
            @(negedge clk);
            #1;
            if (dut.ad_en === 1'b1 && read === 1'b0) viol++;
        end
        cmd_valid = 1'b0;
        repeat (10) begin
            tick();
            if (rsp_valid === 1'b1) begin
                if (sb.size() == 0) unexp++;
                else begin
                    x = sb.pop_front();
                    checks++; if (rsp_data !== x.data) begin errors++; $display("[TB] FAIL rand_rd_data: got %h want %h", rsp_data, x.data); end
                end
            end
        end
        checks++; if (viol != 0) begin errors++; $display("[TB] FAIL rand_drive_vs_read: got %0d overlaps want 0", viol); end
        checks++; if (unexp != 0) begin errors++; $display("[TB] FAIL rand_unexpected_rsp: got %0d want 0", unexp); end
        checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL rand_missing_rsp: got %0d pending want 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_back_to_back();
        int   acc_k[$];
        logic swap;
        int   nrsp;
        exp_t x;
        cmd_write3 = 1'b1;
        cmd_data3  = 32'h1234_5678;
        cmd_valid3 = 1'b1;
        swap = 1'b0;
        nrsp = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (swap) begin
                swap = 1'b0;
                if (acc_k.size() == 4) cmd_valid3 = 1'b0;
                else cmd_write3 = ~cmd_write3;
            end
            if (rsp_valid3 === 1'b1) begin
                nrsp++;
                if (sb.size() == 0) begin
                    checks++; errors++; $display("[TB] FAIL b2b_unexpected_rsp: got %h want none", rsp_data3);
                end else begin
                    x = sb.pop_front();
                    checks++; if (rsp_data3 !== x.data) begin errors++; $display("[TB] FAIL b2b_rd_data: got %h want %h", rsp_data3, x.data); end
                    checks++; if (rsp_err3 !== x.err) begin errors++; $display("[TB] FAIL b2b_rd_err: got %b want %b", rsp_err3, x.err); end
                end
            end
            if (cmd_valid3 === 1'b1 && cmd_ready3 === 1'b1) begin
                acc_k.push_back(k);
                swap = 1'b1;
                if (!cmd_write3) sb.push_back(mk_exp(1'b0, 1'b0, 32'h0000_5678));
            end
        end
        checks++; if (acc_k.size() != 4) begin errors++; $display("[TB] FAIL b2b_accepts: got %0d want 4", acc_k.size()); end
        if (acc_k.size() == 4) begin
            checks++; if (acc_k[1] - acc_k[0] != 4) begin errors++; $display("[TB] FAIL b2b_wr_spacing: got %0d want 4", acc_k[1] - acc_k[0]); end
            checks++; if (acc_k[2] - acc_k[1] != 6) begin errors++; $display("[TB] FAIL b2b_rd_spacing: got %0d want 6", acc_k[2] - acc_k[1]); end
            checks++; if (acc_k[3] - acc_k[2] != 4) begin errors++; $display("[TB] FAIL b2b_wr2_spacing: got %0d want 4", acc_k[3] - acc_k[2]); end
        end
        checks++; if (nrsp != 2) begin errors++; $display("[TB] FAIL b2b_rsp_count: got %0d want 2", nrsp); end
    endtask

    // Sequence of scenarios followed by the single summary line.
    initial begin
        logic probe;
        probe      = 1'bx;
        four_state = (probe === 1'bx);
        $display("[TB] start, four_state=%0b", four_state);
        test_reset();
        test_write_read();
        test_reset_mid_write();
        test_turnaround();
        test_floating();
        test_busy_ignore();
        test_random_invariant();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
